// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage.
// Registers the decoded operands and control coming out of ID, resolves
// EX/MEM and MEM/WB forwarding for both ALU operands and the store data,
// detects load-use hazards, inserts bubbles and counts them.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_*                 decoded instruction from ID (valid, read data,
//                        immediate, register indices, 9-bit control)
//   stall_in / flush     downstream stall (hold) / branch squash
//   mem_* / wb_*         EX/MEM and MEM/WB writeback info for forwarding
//   ex_valid             EX holds a real instruction
//   alu_a, alu_b, alu_op ALU operand and opcode feed
//   ex_store_data        forwarded Rt for stores
//   ex_rdst, ex_ctrl_wb  registered destination and downstream control
//   id_hold              upstream must hold PC and IF/ID
//   bubble_cnt           saturating count of inserted load-use bubbles
module id_ex_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rdst,
  input  logic [8:0]        id_ctrl,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rdst,
  output logic [4:0]        ex_ctrl_wb,
  output logic              id_hold,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  // control layout: {ALUSrc, ALUOp[2:0], RegWrite, MemRead, MemWrite, MemtoReg, Branch}
  localparam int unsigned C_ALUSRC  = 8;
  localparam int unsigned C_MEMREAD = 3;

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] rd1_q,    rd1_d;
  logic [DATA_W-1:0] rd2_q,    rd2_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [REG_W-1:0]  rn_q,     rn_d;
  logic [REG_W-1:0]  rm_q,     rm_d;
  logic [REG_W-1:0]  rdst_q,   rdst_d;
  logic [8:0]        ctrl_q,   ctrl_d;
  logic [CNT_W-1:0]  bcnt_q,   bcnt_d;

  logic load_use;
  logic [DATA_W-1:0] fwd_rn, fwd_rm;

  // XZR always reads zero and is never a forwarding match.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  s,
    input logic [DATA_W-1:0] reg_data,
    input logic              m_we,
    input logic [REG_W-1:0]  m_rd,
    input logic [DATA_W-1:0] m_val,
    input logic              w_we,
    input logic [REG_W-1:0]  w_rd,
    input logic [DATA_W-1:0] w_val
  );
    if (s == XZR)                    return '0;
    else if (m_we && (m_rd == s))    return m_val;
    else if (w_we && (w_rd == s))    return w_val;
    else                             return reg_data;
  endfunction

  always_comb begin
    load_use = valid_q && ctrl_q[C_MEMREAD] && (rdst_q != XZR) && id_valid &&
               ((rdst_q == id_rn) || (rdst_q == id_rm));
    id_hold  = load_use || stall_in;
  end

  always_comb begin
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rdst_d  = rdst_q;
    ctrl_d  = ctrl_q;
    bcnt_d  = bcnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall_in) begin
      // hold everything
    end else if (load_use) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
    end else begin
      valid_d = id_valid;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rn_d    = id_rn;
      rm_d    = id_rm;
      rdst_d  = id_rdst;
      ctrl_d  = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      rdst_q  <= '0;
      ctrl_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rdst_q  <= rdst_d;
      ctrl_q  <= ctrl_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    fwd_rn = fwd(rn_q, rd1_q, mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data);
    fwd_rm = fwd(rm_q, rd2_q, mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_data);
  end

  assign ex_valid      = valid_q;
  assign alu_a         = fwd_rn;
  assign alu_b         = ctrl_q[C_ALUSRC] ? imm_q : fwd_rm;
  assign ex_store_data = fwd_rm;
  assign alu_op        = valid_q ? ctrl_q[7:5] : 3'b000;
  assign ex_rdst       = rdst_q;
  assign ex_ctrl_wb    = valid_q ? ctrl_q[4:0] : 5'b00000;
  assign bubble_cnt    = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 32;

  // {ALUSrc, ALUOp[2:0], RegWrite, MemRead, MemWrite, MemtoReg, Branch}
  localparam logic [8:0] C_ADD  = 9'b0_000_10000;
  localparam logic [8:0] C_LDUR = 9'b1_000_11010;
  localparam logic [8:0] C_SUBI = 9'b1_001_10000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [REG_W-1:0]  id_rn, id_rm, id_rdst;
  logic [8:0]        id_ctrl;
  logic              stall_in, flush;
  logic              mem_regwrite;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_regwrite;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [DATA_W-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0]        alu_op;
  logic [REG_W-1:0]  ex_rdst;
  logic [4:0]        ex_ctrl_wb;
  logic              id_hold;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rn(id_rn), .id_rm(id_rm), .id_rdst(id_rdst), .id_ctrl(id_ctrl),
    .stall_in(stall_in), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_rdst(ex_rdst), .ex_ctrl_wb(ex_ctrl_wb),
    .id_hold(id_hold), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [8:0] c,
                        input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    id_valid = v; id_ctrl = c; id_rd1 = r1; id_rd2 = r2; id_imm = im;
    id_rn = rn; id_rm = rm; id_rdst = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    stall_in = 0; flush = 0;
    mem_regwrite = 0; mem_rd = '0; mem_result = '0;
    wb_regwrite = 0; wb_rd = '0; wb_data = '0;
    #12;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_ctrl_wb", 64'(ex_ctrl_wb), 64'd0);
    chk("rst_bcnt", 64'(bubble_cnt), 64'd0);
    chk("rst_hold", 64'(id_hold), 64'd0);

    // ADD 5,7 then asynchronous reset between edges
    rst_n = 1'b1;
    set_id(1'b1, C_ADD, 64'd5, 64'd7, '0, 5'd1, 5'd2, 5'd3);
    step();
    chk("add_valid", 64'(ex_valid), 64'd1);
    chk("add_alu_a", alu_a, 64'd5);
    chk("add_alu_b", alu_b, 64'd7);
    chk("add_ctrl_wb", 64'(ex_ctrl_wb), 64'b10000);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_alu_a", alu_a, 64'd0);
    chk("arst_alu_op", 64'(alu_op), 64'd0);
    chk("arst_ctrl_wb", 64'(ex_ctrl_wb), 64'd0);
    #2 rst_n = 1'b1;

    // basic load
    set_id(1'b1, C_ADD, 64'h10, 64'h20, '0, 5'd1, 5'd2, 5'd3);
    step();
    chk("basic_alu_a", alu_a, 64'h10);
    chk("basic_alu_b", alu_b, 64'h20);
    chk("basic_alu_op", 64'(alu_op), 64'd0);
    chk("basic_valid", 64'(ex_valid), 64'd1);
    chk("basic_rdst", 64'(ex_rdst), 64'd3);

    // forwarding priority on rn=3
    set_id(1'b1, C_ADD, 64'h11, 64'h22, '0, 5'd3, 5'd5, 5'd6);
    step();
    mem_regwrite = 1; mem_rd = 5'd3; mem_result = 64'hAA;
    wb_regwrite = 1;  wb_rd = 5'd3;  wb_data = 64'hBB;
    #1;
    chk("fwd_mem_first", alu_a, 64'hAA);
    chk("fwd_rm_none", alu_b, 64'h22);
    mem_regwrite = 0;
    #1;
    chk("fwd_wb", alu_a, 64'hBB);
    // rn=31 reads zero even with a matching forward on 31
    mem_regwrite = 1; mem_rd = 5'd31; wb_rd = 5'd31;
    set_id(1'b1, C_ADD, 64'h77, 64'h88, '0, 5'd31, 5'd5, 5'd6);
    step();
    chk("xzr_alu_a", alu_a, 64'd0);
    chk("xzr_alu_b", alu_b, 64'h88);
    mem_regwrite = 0; wb_regwrite = 0; mem_rd = '0; wb_rd = '0;

    // load-use: LDUR x4, then ADD using rm=4
    set_id(1'b1, C_LDUR, 64'h1000, 64'h0, 64'h8, 5'd1, 5'd2, 5'd4);
    step();
    chk("ldur_ctrl_wb", 64'(ex_ctrl_wb), 64'b11010);
    set_id(1'b1, C_ADD, 64'h100, 64'h200, '0, 5'd7, 5'd4, 5'd8);
    #1;
    chk("lu_hold", 64'(id_hold), 64'd1);
    step();
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_ctrl", 64'(ex_ctrl_wb), 64'd0);
    chk("lu_bubble_op", 64'(alu_op), 64'd0);
    chk("lu_bcnt", 64'(bubble_cnt), 64'd1);
    chk("lu_hold_clear", 64'(id_hold), 64'd0);
    step();
    chk("lu_dep_valid", 64'(ex_valid), 64'd1);
    chk("lu_dep_alu_a", alu_a, 64'h100);
    chk("lu_dep_alu_b", alu_b, 64'h200);
    chk("lu_dep_rdst", 64'(ex_rdst), 64'd8);

    // load to XZR never creates a hazard
    set_id(1'b1, C_LDUR, 64'h1000, 64'h0, 64'h8, 5'd1, 5'd2, 5'd31);
    step();
    set_id(1'b1, C_ADD, 64'h1, 64'h2, '0, 5'd31, 5'd31, 5'd9);
    #1;
    chk("xzr_lu_hold", 64'(id_hold), 64'd0);
    step();
    chk("xzr_lu_valid", 64'(ex_valid), 64'd1);
    chk("xzr_lu_bcnt", 64'(bubble_cnt), 64'd1);

    // stall for three cycles, then flush during stall
    set_id(1'b1, C_ADD, 64'h55, 64'h66, '0, 5'd9, 5'd10, 5'd11);
    step();
    stall_in = 1;
    set_id(1'b1, C_LDUR, 64'hDEAD, 64'hBEEF, 64'h4, 5'd11, 5'd11, 5'd12);
    #1;
    chk("stall_hold", 64'(id_hold), 64'd1);
    step(); step(); step();
    chk("stall_alu_a", alu_a, 64'h55);
    chk("stall_alu_b", alu_b, 64'h66);
    chk("stall_rdst", 64'(ex_rdst), 64'd11);
    chk("stall_valid", 64'(ex_valid), 64'd1);
    chk("stall_ctrl_wb", 64'(ex_ctrl_wb), 64'b10000);
    flush = 1;
    step();
    chk("flush_valid", 64'(ex_valid), 64'd0);
    chk("flush_ctrl_wb", 64'(ex_ctrl_wb), 64'd0);
    chk("flush_bcnt", 64'(bubble_cnt), 64'd1);
    flush = 0; stall_in = 0;

    // immediate path with forwarded rm and rn
    set_id(1'b1, C_SUBI, 64'h3, 64'h9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 5'd13, 5'd14);
    step();
    mem_regwrite = 1; mem_rd = 5'd13; mem_result = 64'h1234;
    wb_regwrite = 1;  wb_rd = 5'd12;  wb_data = 64'h5678;
    #1;
    chk("imm_alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("imm_store", ex_store_data, 64'h1234);
    chk("imm_alu_a", alu_a, 64'h5678);
    chk("imm_alu_op", 64'(alu_op), 64'd1);
    chk("imm_bcnt", 64'(bubble_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
